// File: rtl/ifetch_queue_pkg.sv
// Shared cpu defaults for the fetch path.
// Address/instruction widths and reset vector.
package ifetch_queue_pkg;
  localparam int unsigned CPU_AWIDTH   = 16;
  localparam int unsigned CPU_IWIDTH   = 16;
  localparam int unsigned CPU_RESET_PC = 0;
endpackage

// File: rtl/ifq_store.sv
// Prefetch queue storage: one write port, one async read port.
// No reset; the consumer zero-gates the read data.
module ifq_store #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with DEPTH-entry prefetch queue,
// data-port priority and branch flush/squash.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned AWIDTH   = CPU_AWIDTH,
  parameter int unsigned IWIDTH   = CPU_IWIDTH,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = CPU_RESET_PC,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AWIDTH-1:0] mem_raddr_o,
  output logic              mem_rd_o,
  input  logic [IWIDTH-1:0] mem_rdata_i,
  input  logic              mem_busy_i,
  input  logic              br_valid_i,
  input  logic [AWIDTH-1:0] br_target_i,
  output logic [IWIDTH-1:0] ir_o,
  output logic [AWIDTH-1:0] ir_pc_o,
  output logic              ir_valid_o,
  input  logic              ir_ready_i,
  output logic [CW-1:0]     count_o
);

  localparam int unsigned EW = AWIDTH + IWIDTH;
  localparam logic [AWIDTH-1:0] A_ONE = AWIDTH'(1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [AWIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic              inflight;
  logic [AWIDTH-1:0] inflight_pc;
  logic              squash;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count, count_nxt;

  logic          push, pop, room, issue;
  logic [CW:0]   occ;
  logic [EW-1:0] rd_entry;

  assign ir_valid_o = (count != '0);
  assign pop  = ir_ready_i & ir_valid_o & ~br_valid_i;
  assign push = inflight & ~squash & ~br_valid_i;

  // In-flight read already owns a slot; a same-cycle pop earns no credit.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign room  = (occ < FULL);
  assign issue = rst_n & ~mem_busy_i & (br_valid_i | room);

  assign mem_rd_o    = issue;
  assign mem_raddr_o = (br_valid_i & issue) ? br_target_i : fetch_pc;

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (br_valid_i)
      fetch_pc_nxt = mem_busy_i ? br_target_i
                                : br_target_i + A_ONE;
    else if (issue)
      fetch_pc_nxt = fetch_pc + A_ONE;
  end

  always_comb begin
    count_nxt = count;
    if (br_valid_i)
      count_nxt = '0;
    else if (push & ~pop)
      count_nxt = count + C_ONE;
    else if (pop & ~push)
      count_nxt = count - C_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= AWIDTH'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= mem_raddr_o;
      count <= count_nxt;
      if (br_valid_i) begin
        squash <= 1'b0;
        head   <= '0;
        tail   <= '0;
      end else begin
        if (push) tail <= tail + P_ONE;
        if (pop)  head <= head + P_ONE;
      end
    end
  end

  ifq_store #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_store (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata ({inflight_pc, mem_rdata_i}),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign ir_o    = ir_valid_o ? rd_entry[IWIDTH-1:0] : '0;
  assign ir_pc_o = ir_valid_o ? rd_entry[EW-1:IWIDTH] : '0;
  assign count_o = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed vector bench for ifetch_queue.
// Memory model returns 0x1000 + address one cycle later.
module tb_ifetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut1: RESET_PC = 0
  logic        rst1_n, busy1, br1, rdy1;
  logic [15:0] tgt1, raddr1, rdata1, ir1, pc1, last1;
  logic        rd1, val1;
  logic [2:0]  cnt1;

  // dut2: RESET_PC = 0xFFFE
  logic        rst2_n, busy2, br2, rdy2;
  logic [15:0] tgt2, raddr2, rdata2, ir2, pc2, last2;
  logic        rd2, val2;
  logic [2:0]  cnt2;

  ifetch_queue #(.DEPTH(4), .RESET_PC(0)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .mem_raddr_o(raddr1), .mem_rd_o(rd1),
    .mem_rdata_i(rdata1), .mem_busy_i(busy1),
    .br_valid_i(br1), .br_target_i(tgt1),
    .ir_o(ir1), .ir_pc_o(pc1), .ir_valid_o(val1),
    .ir_ready_i(rdy1), .count_o(cnt1)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .mem_raddr_o(raddr2), .mem_rd_o(rd2),
    .mem_rdata_i(rdata2), .mem_busy_i(busy2),
    .br_valid_i(br2), .br_target_i(tgt2),
    .ir_o(ir2), .ir_pc_o(pc2), .ir_valid_o(val2),
    .ir_ready_i(rdy2), .count_o(cnt2)
  );

  always_ff @(posedge clk) begin
    last1 <= raddr1;
    last2 <= raddr2;
  end
  assign rdata1 = 16'h1000 + last1;
  assign rdata2 = 16'h1000 + last2;

  typedef struct {
    logic        busy;
    logic        br;
    logic [15:0] tgt;
    logic        ready;
    logic        rd;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] iw(input logic v,
                                     input logic [15:0] p);
    return v ? 16'h1000 + p : 16'h0000;
  endfunction

  task automatic chk1(input string nm, input logic rd,
                      input logic [15:0] a, input logic v,
                      input logic [15:0] p, input logic [2:0] c);
    chk({nm, ".rd"},    32'(rd1),   32'(rd));
    chk({nm, ".addr"},  32'(raddr1), 32'(a));
    chk({nm, ".valid"}, 32'(val1),  32'(v));
    chk({nm, ".pc"},    32'(pc1),   32'(v ? p : 16'h0));
    chk({nm, ".ir"},    32'(ir1),   32'(iw(v, p)));
    chk({nm, ".count"}, 32'(cnt1),  32'(c));
  endtask

  initial begin
    // busy br tgt ready | rd addr valid pc cnt
    tbl[0]  = '{0,0,16'h0,1, 1,16'h0000,0,16'h0000,0};
    tbl[1]  = '{0,0,16'h0,1, 1,16'h0001,0,16'h0000,0};
    tbl[2]  = '{0,0,16'h0,1, 1,16'h0002,1,16'h0000,1};
    tbl[3]  = '{0,0,16'h0,1, 1,16'h0003,1,16'h0001,1};
    tbl[4]  = '{0,0,16'h0,1, 1,16'h0004,1,16'h0002,1};
    tbl[5]  = '{1,0,16'h0,1, 0,16'h0005,1,16'h0003,1};
    tbl[6]  = '{1,0,16'h0,1, 0,16'h0005,1,16'h0004,1};
    tbl[7]  = '{0,0,16'h0,1, 1,16'h0005,0,16'h0000,0};
    tbl[8]  = '{0,0,16'h0,1, 1,16'h0006,0,16'h0000,0};
    tbl[9]  = '{0,0,16'h0,1, 1,16'h0007,1,16'h0005,1};
    tbl[10] = '{0,0,16'h0,0, 1,16'h0008,1,16'h0006,1};
    tbl[11] = '{0,0,16'h0,0, 1,16'h0009,1,16'h0006,2};
    tbl[12] = '{0,0,16'h0,0, 0,16'h000A,1,16'h0006,3};
    tbl[13] = '{0,0,16'h0,0, 0,16'h000A,1,16'h0006,4};
    tbl[14] = '{0,0,16'h0,1, 0,16'h000A,1,16'h0006,4};
    tbl[15] = '{0,0,16'h0,0, 1,16'h000A,1,16'h0007,3};
    tbl[16] = '{0,1,16'h0200,0, 1,16'h0200,1,16'h0007,3};
    tbl[17] = '{0,0,16'h0,1, 1,16'h0201,0,16'h0000,0};
    tbl[18] = '{0,0,16'h0,1, 1,16'h0202,1,16'h0200,1};
    tbl[19] = '{0,0,16'h0,1, 1,16'h0203,1,16'h0201,1};
    tbl[20] = '{1,1,16'h0300,1, 0,16'h0204,1,16'h0202,1};
    tbl[21] = '{0,0,16'h0,1, 1,16'h0300,0,16'h0000,0};
    tbl[22] = '{0,0,16'h0,1, 1,16'h0301,0,16'h0000,0};
    tbl[23] = '{0,0,16'h0,1, 1,16'h0302,1,16'h0300,1};
    tbl[24] = '{0,0,16'h0,1, 1,16'h0303,1,16'h0301,1};

    rst1_n = 1'b0; busy1 = 0; br1 = 0; tgt1 = '0; rdy1 = 1;
    rst2_n = 1'b0; busy2 = 0; br2 = 0; tgt2 = '0; rdy2 = 1;
    tick();
    tick();
    chk1("reset", 1'b0, 16'h0000, 1'b0, 16'h0, 3'd0);

    rst1_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      busy1 = tbl[i].busy;
      br1   = tbl[i].br;
      tgt1  = tbl[i].tgt;
      rdy1  = tbl[i].ready;
      #1;
      chk1($sformatf("vec%0d", i), tbl[i].rd, tbl[i].addr,
           tbl[i].valid, tbl[i].pc, tbl[i].cnt);
      tick();
    end

    // async reset mid-stream, no clock edge
    busy1 = 0; br1 = 0; tgt1 = '0; rdy1 = 1;
    rst1_n = 1'b0;
    #1;
    chk1("midrst", 1'b0, 16'h0000, 1'b0, 16'h0, 3'd0);
    tick();
    rst1_n = 1'b1;
    #1;
    chk1("rel0", 1'b1, 16'h0000, 1'b0, 16'h0, 3'd0);
    tick();
    chk1("rel1", 1'b1, 16'h0001, 1'b0, 16'h0, 3'd0);
    tick();
    chk1("rel2", 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1);

    // wrap from RESET_PC = 0xFFFE
    tick();
    rst2_n = 1'b1;
    #1;
    chk("wrap0.rd",   32'(rd2),    32'd1);
    chk("wrap0.addr", 32'(raddr2), 32'h0000FFFE);
    tick();
    chk("wrap1.addr", 32'(raddr2), 32'h0000FFFF);
    chk("wrap1.valid", 32'(val2),  32'd0);
    tick();
    chk("wrap2.pc",   32'(pc2),    32'h0000FFFE);
    chk("wrap2.ir",   32'(ir2),    32'h00000FFE);
    chk("wrap2.addr", 32'(raddr2), 32'h00000000);
    tick();
    chk("wrap3.pc",   32'(pc2),    32'h0000FFFF);
    chk("wrap3.ir",   32'(ir2),    32'h00000FFF);
    tick();
    chk("wrap4.pc",   32'(pc2),    32'h00000000);
    chk("wrap4.ir",   32'(ir2),    32'h00001000);
    chk("wrap4.cnt",  32'(cnt2),   32'd1);
    tick();
    rst2_n = 1'b0;
    #1;
    chk("wraprst.valid", 32'(val2),  32'd0);
    chk("wraprst.count", 32'(cnt2),  32'd0);
    chk("wraprst.rd",    32'(rd2),   32'd0);
    chk("wraprst.addr",  32'(raddr2), 32'h0000FFFE);
    chk("wraprst.ir",    32'(ir2),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit for the next-generation cpu core. It replaces the single-entry ir/ir_valid/ir_loading fetch logic with a DEPTH-entry prefetch queue. It also gives data loads priority over instruction fetch and handles branch redirect with flush and squash of in-flight reads. The block sits between the shared synchronous memory read port and the decode stage, and presents each instruction together with its own address.

## Interface
- AWIDTH, 16: instruction address width.
- IWIDTH, 16: instruction word width.
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 0: first fetch address after reset.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_raddr_o  out  AWIDTH  fetch address. Equals fetch_pc when no fetch is issued.
- mem_rd_o  out  1  fetch issued this cycle.
- mem_rdata_i  in  IWIDTH  read data, valid exactly one cycle after the request.
- mem_busy_i  in  1  data port owns memory this cycle; no fetch may issue.
- br_valid_i  in  1  redirect request, single-cycle pulse.
- br_target_i  in  AWIDTH  redirect address.
- ir_o  out  IWIDTH  head instruction; 0 when ir_valid_o is low.
- ir_pc_o  out  AWIDTH  address of ir_o; 0 when ir_valid_o is low.
- ir_valid_o  out  1  queue is non-empty.
- ir_ready_i  in  1  decode consumes the head this cycle. Ignored when ir_valid_o is low.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- State:
  - fetch_pc (AWIDTH).
  - inflight flag and inflight_pc.
  - squash flag.
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - count.
- Issue condition: not mem_busy_i, rst_n high, and (count + inflight) < DEPTH. The full check gets no credit for a pop in the same cycle.
- On issue without a branch: mem_raddr_o = fetch_pc, fetch_pc <= fetch_pc+1, inflight <= 1, inflight_pc <= fetch_pc.
- Response: when inflight is high and squash is low, write {inflight_pc, mem_rdata_i} at tail, then increment tail.
- Pop: when ir_ready_i and ir_valid_o are both high, increment head.
- Push and pop in the same cycle leave count unchanged.
- Branch (br_valid_i high):
  - Flush the queue: head = tail = count = 0.
  - Discard any response arriving this cycle.
  - Set squash <= 0.
  - If not mem_busy_i: mem_raddr_o = br_target_i, mem_rd_o = 1, fetch_pc <= br_target_i+1, inflight_pc <= br_target_i.
  - If mem_busy_i: fetch_pc <= br_target_i and no fetch is issued.
  - A pop in the same cycle is ignored.
- Arithmetic: fetch_pc wraps modulo 2^AWIDTH, so 0xFFFF+1 = 0x0000 when AWIDTH is 16.
- No state machine beyond the flags above. The block is a pure queue plus issue logic.

## Timing
- Reset, asynchronous, taking effect immediately:
  - mem_rd_o=0, mem_raddr_o=RESET_PC.
  - ir_valid_o=0, ir_o=0, ir_pc_o=0, count_o=0.
  - inflight=0, squash=0.
- First fetch (address RESET_PC) issues in the first cycle with rst_n high.
- Fetch latency: request in cycle N, data in cycle N+1, ir_valid_o high in N+2. There is no bypass path.
- Branch in cycle N with mem_busy_i low: target instruction appears on ir_o in N+2. ir_valid_o is low in N+1.
- Sustained throughput with mem_busy_i low and ir_ready_i high: one instruction per cycle.
- One mem_busy_i cycle causes a one-cycle fetch bubble only. Queued entries keep draining.
- Full queue (count=DEPTH): no issue. mem_rd_o resumes the cycle after a pop.
- Reset asserted mid-operation: all state is cleared at once and the in-flight response is never written.

## Structure
- Shared cpu include: AWIDTH, IWIDTH and RESET_PC defaults, used by cpu and this block.
- One sub-module, ifq_store: a DEPTH x (AWIDTH+IWIDTH) register array.
  - One write port (tail) and one asynchronous read port (head).
  - Write enable only; no reset on storage, since the output is zero-gated by ir_valid_o.
- Pointer, count, issue and branch logic live in ifetch_queue.

## Test plan
- Reset release, mem_rdata_i = 0x1000+addr, ir_ready_i=1:
  - mem_rd_o=1 with mem_raddr_o=0x0000 in cycle 0.
  - ir_o=0x1000, ir_pc_o=0 in cycle 2.
  - Then 0x1001, 0x1002 on consecutive cycles.
- ir_ready_i=0, DEPTH=4:
  - count_o reaches 4 and mem_rd_o stays 0.
  - Raise ir_ready_i for one cycle: count_o drops to 3, then a fetch of address 4 issues.
- With 3 entries queued and a fetch in flight, pulse br_valid_i with target 0x0200:
  - Next cycle: count_o=0, ir_valid_o=0.
  - Two cycles later: ir_pc_o=0x0200.
  - The stale in-flight word never appears.
- Branch with mem_busy_i=1 in the same cycle, target 0x0300:
  - No fetch in that cycle.
  - Fetch of 0x0300 issues the next cycle.
  - ir_pc_o=0x0300 three cycles after the branch.
- mem_busy_i high for 2 cycles during streaming:
  - mem_rd_o=0 for exactly those cycles.
  - ir_pc_o sequence has no gaps or duplicates.
- RESET_PC=0xFFFE, streaming:
  - ir_pc_o sequence 0xFFFE, 0xFFFF, 0x0000.
  - Assert rst_n low mid-stream: ir_valid_o=0 and count_o=0 with no clock edge.
